// File: rtl/message_scheduler.sv
// SHA-256 message scheduler: supplies W[t] per STN round, expands in a 16-word ring.
// Optional protocol checking enabled by defining SCHED_OVERRUN_CHECK_EN.
module message_scheduler (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [511:0] block_in,
    input  logic         STN,
    output logic [31:0]  Wt_out,
    output logic         busy,
    output logic         done,
    output logic         overrun
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_READY     = 3'd1;
    localparam logic [2:0] S_ADD1      = 3'd2;
    localparam logic [2:0] S_ADD2      = 3'd3;
    localparam logic [2:0] S_ADD3      = 3'd4;
    localparam logic [2:0] S_WAIT_FALL = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [6:0]  t_q, t_d;
    logic [31:0] acc_q, acc_d;
    logic        stn_q;
    logic [31:0] w_buf_q [16];

    logic        stn_rise, stn_fall;
    logic        wb_en;
    logic [3:0]  idx1, idx9, idx14;
    logic [31:0] add_a, add_b, sum;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign stn_rise = STN & ~stn_q;
    assign stn_fall = ~STN & stn_q;

    assign idx1  = ptr_q + 4'd1;
    assign idx9  = ptr_q + 4'd9;
    assign idx14 = ptr_q + 4'd14;

    assign Wt_out = w_buf_q[ptr_q];
    assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done   = (state_q == S_DONE);

    // Operand select for the single shared adder across ADD1..ADD3
    always_comb begin
        add_a = acc_q;
        add_b = '0;
        case (state_q)
            S_ADD1: begin
                add_a = w_buf_q[ptr_q];
                add_b = w_buf_q[idx9];
            end
            S_ADD2:  add_b = ssig0(w_buf_q[idx1]);
            S_ADD3:  add_b = ssig1(w_buf_q[idx14]);
            default: add_b = '0;
        endcase
    end

    assign sum = add_a + add_b;

    // Next-state logic; load overrides any STN activity
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        t_d     = t_q;
        acc_d   = acc_q;
        wb_en   = 1'b0;
        if (load) begin
            state_d = S_READY;
            ptr_d   = '0;
            t_d     = '0;
        end else begin
            case (state_q)
                S_READY: begin
                    if (stn_rise)
                        state_d = (t_q < 7'd48) ? S_ADD1 : S_WAIT_FALL;
                end
                S_ADD1: begin
                    acc_d   = sum;
                    state_d = S_ADD2;
                end
                S_ADD2: begin
                    acc_d   = sum;
                    state_d = S_ADD3;
                end
                S_ADD3: begin
                    acc_d   = sum;
                    state_d = S_WAIT_FALL;
                end
                S_WAIT_FALL: begin
                    if (stn_fall) begin
                        wb_en   = (t_q < 7'd48);
                        ptr_d   = ptr_q + 4'd1;
                        t_d     = t_q + 7'd1;
                        state_d = (t_q == 7'd63) ? S_DONE : S_READY;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, counters, edge register and word ring
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            t_q     <= '0;
            acc_q   <= '0;
            stn_q   <= 1'b0;
            for (int i = 0; i < 16; i++)
                w_buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
            stn_q   <= STN;
            if (load) begin
                for (int i = 0; i < 16; i++)
                    w_buf_q[i] <= block_in[511-32*i -: 32];
            end else if (wb_en) begin
                w_buf_q[ptr_q] <= acc_q;
            end
        end
    end

`ifdef SCHED_OVERRUN_CHECK_EN
    logic overrun_q;
    logic ovr_set;

    assign ovr_set =
        (stn_rise && (state_q == S_ADD1 || state_q == S_ADD2 ||
                      state_q == S_ADD3 || state_q == S_WAIT_FALL)) ||
        (stn_fall && (state_q == S_READY || state_q == S_ADD1 ||
                      state_q == S_ADD2 || state_q == S_ADD3));

    // Sticky protocol error, cleared by reset or a new block
    always_ff @(posedge clk) begin
        if (!rst_n)
            overrun_q <= 1'b0;
        else if (load)
            overrun_q <= 1'b0;
        else if (ovr_set)
            overrun_q <= 1'b1;
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_message_scheduler.sv
// Randomized self-checking bench for message_scheduler.
// Reference: full 64-word SHA-256 schedule computed from the block up front.
module tb_message_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load;
    logic [511:0] block_in;
    logic         STN;
    logic [31:0]  Wt_out;
    logic         busy;
    logic         done;
    logic         overrun;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    logic [31:0] wexp [64];

`ifdef SCHED_OVERRUN_CHECK_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    message_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .block_in (block_in),
        .STN      (STN),
        .Wt_out   (Wt_out),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    task automatic compute_w(input logic [511:0] b);
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) wexp[i] = b[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(wexp[i-15], 7) ^ rotr(wexp[i-15], 18) ^ (wexp[i-15] >> 3);
            s1 = rotr(wexp[i-2], 17) ^ rotr(wexp[i-2], 19) ^ (wexp[i-2] >> 10);
            wexp[i] = s1 + wexp[i-7] + s0 + wexp[i-16];
        end
    endtask

    task automatic do_load(input logic [511:0] b);
        block_in = b;
        compute_w(b);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        tot_cnt++;
        if (Wt_out !== wexp[0] || busy !== 1'b1 || done !== 1'b0 || overrun !== 1'b0)
            $display("FAIL load: Wt=%h busy=%b done=%b ovr=%b, want Wt=%h busy=1 done=0 ovr=0",
                     Wt_out, busy, done, overrun, wexp[0]);
        else pass_cnt++;
    endtask

    task automatic run_round(input int t, input int hi, input int lo);
        STN = 1'b1;
        repeat (hi) begin
            @(negedge clk);
            tot_cnt++;
            if (Wt_out !== wexp[t] || busy !== 1'b1 || done !== 1'b0 || overrun !== 1'b0)
                $display("FAIL round_hi t=%0d: Wt=%h busy=%b done=%b ovr=%b, want Wt=%h 1 0 0",
                         t, Wt_out, busy, done, overrun, wexp[t]);
            else pass_cnt++;
        end
        STN = 1'b0;
        for (int c = 0; c < lo; c++) begin
            @(negedge clk);
            tot_cnt++;
            if (t < 63) begin
                if (Wt_out !== wexp[t+1] || busy !== 1'b1 || done !== 1'b0)
                    $display("FAIL round_lo t=%0d: Wt=%h busy=%b done=%b, want Wt=%h 1 0",
                             t, Wt_out, busy, done, wexp[t+1]);
                else pass_cnt++;
            end else begin
                if (busy !== 1'b0 || done !== (c == 0))
                    $display("FAIL done_pulse c=%0d: busy=%b done=%b, want busy=0 done=%b",
                             c, busy, done, (c == 0));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; STN = 1'b0; block_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tot_cnt++;
        if (Wt_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0)
            $display("FAIL reset: Wt=%h busy=%b done=%b ovr=%b, want all 0",
                     Wt_out, busy, done, overrun);
        else pass_cnt++;
    endtask

    task automatic test_idle_edges();
        for (int i = 0; i < 6; i++) begin
            STN = i[0];
            @(negedge clk);
            tot_cnt++;
            if (Wt_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0)
                $display("FAIL idle_edges: Wt=%h busy=%b done=%b ovr=%b, want all 0",
                         Wt_out, busy, done, overrun);
            else pass_cnt++;
        end
        STN = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abc();
        do_load({32'h61626380, 448'h0, 32'h00000018});
        tot_cnt++;
        if (wexp[16] !== 32'h61626380 || wexp[17] !== 32'h000F0000)
            $display("FAIL abc_model: W16=%h W17=%h, want 61626380 000f0000",
                     wexp[16], wexp[17]);
        else pass_cnt++;
        for (int t = 0; t < 64; t++) begin
            if (t == 16 || t == 17) begin
                tot_cnt++;
                if (Wt_out !== ((t == 16) ? 32'h61626380 : 32'h000F0000))
                    $display("FAIL abc_w%0d: Wt=%h, want %h", t, Wt_out,
                             (t == 16) ? 32'h61626380 : 32'h000F0000);
                else pass_cnt++;
            end
            run_round(t, 4, 4);
        end
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 3; r++) begin
            do_load(rand_block());
            for (int t = 0; t < 64; t++)
                run_round(t, $urandom_range(7, 4), $urandom_range(5, 2));
        end
    endtask

    task automatic test_reload();
        do_load(rand_block());
        for (int t = 0; t < 20; t++) run_round(t, 4, 4);
        do_load(rand_block());
        for (int t = 0; t < 64; t++) run_round(t, 4, 3);
    endtask

    task automatic test_stall();
        do_load(rand_block());
        for (int t = 0; t < 64; t++)
            run_round(t, 4, (t == 47 || t == 48) ? 20 : 4);
    endtask

    task automatic test_reset_mid();
        do_load(rand_block());
        for (int t = 0; t < 30; t++) run_round(t, 4, 4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tot_cnt++;
        if (Wt_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_mid: Wt=%h busy=%b done=%b, want 0 0 0",
                     Wt_out, busy, done);
        else pass_cnt++;
        do_load(rand_block());
        for (int t = 0; t < 64; t++) run_round(t, 5, 2);
    endtask

    task automatic test_overrun();
        do_load(rand_block());
        for (int t = 0; t < 5; t++) run_round(t, 4, 4);
        STN = 1'b1;
        repeat (2) @(negedge clk);
        STN = 1'b0;
        repeat (6) @(negedge clk);
        tot_cnt++;
        if (overrun !== OVR_EN)
            $display("FAIL overrun_set: ovr=%b, want %b", overrun, OVR_EN);
        else pass_cnt++;
        STN = 1'b1;
        repeat (4) @(negedge clk);
        STN = 1'b0;
        repeat (4) @(negedge clk);
        tot_cnt++;
        if (overrun !== OVR_EN)
            $display("FAIL overrun_sticky: ovr=%b, want %b", overrun, OVR_EN);
        else pass_cnt++;
        do_load(rand_block());
        for (int t = 0; t < 64; t++) run_round(t, 4, 2);
    endtask

    initial begin
        test_reset();
        test_idle_edges();
        test_abc();
        test_random_runs();
        test_reload();
        test_stall();
        test_reset_mid();
        test_overrun();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
